// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer: RV32I fetch FSM with PC register, one-outstanding imem    |
// | request, decode-side valid/ready buffer and redirect flush.  Rev 1.0       |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_valid;

  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;
  logic        w_unused;

  assign w_tgt    = {redirect_pc_i[31:2], 2'b00};
  assign w_pc_inc = r_pc + 32'd4;
  assign w_unused = ^redirect_pc_i[1:0];

  assign imem_req_o    = (r_state == S_REQ);
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
    end else if (redirect_i) begin
      // A response already granted must be swallowed in DRAIN before refetching.
      r_pc    <= w_tgt;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE:  r_state <= S_REQ;
        S_REQ:   r_state <= imem_gnt_i ? S_DRAIN : S_REQ;
        S_WAIT:  r_state <= imem_rvalid_i ? S_REQ : S_DRAIN;
        S_HOLD:  r_state <= S_REQ;
        S_DRAIN: r_state <= imem_rvalid_i ? S_REQ : S_DRAIN;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_gnt_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            r_instr    <= imem_rdata_i;
            r_instr_pc <= r_pc;
            r_pc       <= w_pc_inc;
            r_valid    <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Scoreboard bench for fetch_sequencer: a behavioural imem answers grants,
// each test pushes the instructions decode must see in order.
module tb_fetch_sequencer;

  localparam logic [31:0] c_reset_pc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  fetch_sequencer #(.RESET_PC(c_reset_pc)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pops = 0;
  int cyc = 0;
  int hs_cyc_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];

  // Memory model state
  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        p_valid = 1'b0;
  logic [31:0] p_addr = 32'd0;
  int          p_cnt = 0;
  logic [31:0] last_gnt_addr = 32'd0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]} + 32'h0000_0013;
  endfunction

  task automatic expect_fetch(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_ins_q.push_back(memf(pc));
  endtask

  // One clock: drive memory inputs, score any decode handshake, advance model.
  task automatic tick();
    logic s_req, s_gnt;
    logic [31:0] s_addr, ep, ei;
    imem_gnt_i    = imem_req_o && gnt_en;
    imem_rvalid_i = p_valid && (p_cnt == 0);
    imem_rdata_i  = imem_rvalid_i ? memf(p_addr) : 32'hDEAD_BEEF;
    s_req  = imem_req_o;
    s_gnt  = imem_gnt_i;
    s_addr = imem_addr_o;
    if (!rst_i && instr_valid_o === 1'b1 && instr_ready_i) begin
      n_cmp++;
      if (exp_pc_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_instr: got pc=%h instr=%h, required no transfer", instr_pc_o, instr_o);
      end else begin
        ep = exp_pc_q.pop_front();
        ei = exp_ins_q.pop_front();
        if (instr_pc_o !== ep || instr_o !== ei) begin
          n_err++;
          $display("FAIL instr_transfer: got pc=%h instr=%h, required pc=%h instr=%h",
                   instr_pc_o, instr_o, ep, ei);
        end
      end
      pops++;
      hs_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    if (rst_i) begin
      p_valid = 1'b0;
    end else begin
      if (imem_rvalid_i) p_valid = 1'b0;
      else if (p_valid && p_cnt != 0) p_cnt--;
      if (s_req && s_gnt) begin
        p_valid = 1'b1;
        p_addr = s_addr;
        p_cnt = lat - 1;
        last_gnt_addr = s_addr;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_pops(input int n, input int bound);
    int start, k;
    start = pops;
    k = 0;
    while (pops - start < n && k < bound) begin
      tick();
      k++;
    end
    n_cmp++;
    if (pops - start < n) begin
      n_err++;
      $display("FAIL pop_timeout: got %0d transfers, required %0d", pops - start, n);
    end
  endtask

  task automatic wait_valid(input int bound);
    int k;
    k = 0;
    while (instr_valid_o !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    n_cmp++;
    if (instr_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL valid_timeout: got valid=%b, required 1", instr_valid_o);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    instr_ready_i = 1'b0;
    gnt_en = 1'b1;
    lat = 1;
    tick();
    tick();
    rst_i = 1'b0;
    exp_pc_q.delete();
    exp_ins_q.delete();
    hs_cyc_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0 || instr_o !== 32'd0 ||
        instr_pc_o !== 32'd0 || imem_addr_o !== c_reset_pc) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b req=%b instr=%h ipc=%h addr=%h, required 0 0 0 0 %h",
               instr_valid_o, imem_req_o, instr_o, instr_pc_o, imem_addr_o, c_reset_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready_i = 1'b1;
    expect_fetch(32'h100);
    expect_fetch(32'h104);
    expect_fetch(32'h108);
    run_pops(3, 40);
    if (hs_cyc_q.size() >= 3) begin
      n_cmp++;
      if (hs_cyc_q[1] - hs_cyc_q[0] != 3 || hs_cyc_q[2] - hs_cyc_q[1] != 3) begin
        n_err++;
        $display("FAIL stream_rate: got gaps %0d,%0d, required 3,3",
                 hs_cyc_q[1] - hs_cyc_q[0], hs_cyc_q[2] - hs_cyc_q[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    expect_fetch(32'h100);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || instr_o !== memf(32'h100) || instr_pc_o !== 32'h100 ||
          imem_req_o !== 1'b0 || imem_addr_o !== 32'h104) begin
        n_err++;
        $display("FAIL hold_stable: got valid=%b instr=%h ipc=%h req=%b addr=%h, required 1 %h 100 0 104",
                 instr_valid_o, instr_o, instr_pc_o, imem_req_o, imem_addr_o, memf(32'h100));
      end
    end
    instr_ready_i = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h104 || instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL release_req: got req=%b addr=%h valid=%b, required 1 104 0",
               imem_req_o, imem_addr_o, instr_valid_o);
    end
    instr_ready_i = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 3;
    tick();
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_2003;
    tick();
    redirect_i = 1'b0;
    n_cmp++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 32'h2000) begin
      n_err++;
      $display("FAIL redirect_wait_drain: got req=%b valid=%b addr=%h, required 0 0 2000",
               imem_req_o, instr_valid_o, imem_addr_o);
    end
    expect_fetch(32'h2000);
    instr_ready_i = 1'b1;
    run_pops(1, 30);
    n_cmp++;
    if (last_gnt_addr !== 32'h2000) begin
      n_err++;
      $display("FAIL redirect_wait_addr: got %h, required 2000", last_gnt_addr);
    end
    instr_ready_i = 1'b0;
  endtask

  task automatic test_redirect_gnt_rvalid();
    do_reset();
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_3000;
    tick();
    redirect_i = 1'b0;
    n_cmp++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h3000) begin
      n_err++;
      $display("FAIL redirect_gnt: got req=%b addr=%h, required 0 3000", imem_req_o, imem_addr_o);
    end
    expect_fetch(32'h3000);
    instr_ready_i = 1'b1;
    run_pops(1, 20);
    n_cmp++;
    if (last_gnt_addr !== 32'h3000) begin
      n_err++;
      $display("FAIL redirect_gnt_addr: got %h, required 3000", last_gnt_addr);
    end

    do_reset();
    tick();
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_4002;
    tick();
    redirect_i = 1'b0;
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4000) begin
      n_err++;
      $display("FAIL redirect_rvalid: got valid=%b req=%b addr=%h, required 0 1 4000",
               instr_valid_o, imem_req_o, imem_addr_o);
    end
    expect_fetch(32'h4000);
    instr_ready_i = 1'b1;
    run_pops(1, 20);
    instr_ready_i = 1'b0;
  endtask

  task automatic test_redirect_hold();
    do_reset();
    expect_fetch(32'h100);
    wait_valid(20);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_5000;
    instr_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h5000) begin
      n_err++;
      $display("FAIL redirect_hold: got valid=%b req=%b addr=%h, required 0 1 5000",
               instr_valid_o, imem_req_o, imem_addr_o);
    end
    expect_fetch(32'h5000);
    run_pops(1, 20);
    instr_ready_i = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0000_0000);
    instr_ready_i = 1'b1;
    run_pops(1, 20);
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL pc_wrap: got req=%b addr=%h, required 1 00000000", imem_req_o, imem_addr_o);
    end
    run_pops(1, 20);
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lat = 3;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0 || imem_addr_o !== c_reset_pc) begin
      n_err++;
      $display("FAIL reset_in_wait: got valid=%b req=%b addr=%h, required 0 0 %h",
               instr_valid_o, imem_req_o, imem_addr_o, c_reset_pc);
    end
    tick();
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== c_reset_pc) begin
      n_err++;
      $display("FAIL refetch_after_reset: got req=%b addr=%h, required 1 %h",
               imem_req_o, imem_addr_o, c_reset_pc);
    end
    lat = 1;
    expect_fetch(c_reset_pc);
    wait_valid(20);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0 || instr_o !== 32'd0 || instr_pc_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_in_hold: got valid=%b req=%b instr=%h ipc=%h, required 0 0 0 0",
               instr_valid_o, imem_req_o, instr_o, instr_pc_o);
    end
    instr_ready_i = 1'b1;
    run_pops(1, 20);
    instr_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt_rvalid();
    test_redirect_hold();
    test_pc_wrap();
    test_reset_midflight();
    n_cmp++;
    if (exp_pc_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_pc_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
